// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, common command and
// response bytes, and the host-to-device frame builder.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        SEND,
        ACK,
        RELEASE
    } ps2_state_t;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_CMD_ECHO     = 8'hEE;
    localparam logic [7:0] PS2_RESP_ACK     = 8'hFA;
    localparam logic [7:0] PS2_RESP_RESEND  = 8'hFE;

    // Index of the stop bit in the host-to-device shift frame.
    localparam logic [3:0] PS2_LAST_BIT = 4'd9;

    // {stop, odd parity, data}; bit 0 goes on the wire first.
    function automatic logic [9:0] ps2_frame(input logic [7:0] b);
        return {1'b1, ~^b, b};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 line conditioner: two-flop synchronizer, a glitch filter that only
// follows the input after FILTER_CYCLES consecutive differing samples, and a
// one-cycle strobe on each filtered high-to-low transition.
// Idle PS/2 lines are high, so everything resets to 1.
module ps2_line_filter #(
    parameter int FILTER_CYCLES = 19
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic filtered,
    output logic fall
);

    localparam int CW = $clog2(FILTER_CYCLES + 1);

    logic          sync_a;
    logic          sync_b;
    logic [CW-1:0] cnt;

    // Bring the asynchronous pin into the clk domain.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
        end
    end

    // Accept a new level only after it has held for FILTER_CYCLES samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            filtered <= 1'b1;
            cnt      <= '0;
            fall     <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (sync_b == filtered) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_CYCLES - 1)) begin
                filtered <= sync_b;
                cnt      <= '0;
                fall     <= filtered;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter. Sends one command byte to the device over
// open-drain kclk/kdata (an _oe of 1 pulls the pin low), checks the device ACK
// and reports done, ack_err or timeout_err as single-cycle pulses.
// Optional build macro PS2_TX_RETRY_EN: a NACKed byte is resent up to
// MAX_RETRIES times before ack_err is reported.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 1500000,
    parameter int FILTER_CYCLES  = 19,
    parameter int MAX_RETRIES    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       kclk_in,
    input  logic       kdata_in,
    output logic       kclk_oe,
    output logic       kdata_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout_err
);

    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    ps2_state_t state;
    ps2_state_t state_d;

    logic          kclk_filt;
    logic          kclk_fall;
    logic          kdata_filt;
    logic          kdata_fall_unused;  // data edges are not needed here

    logic [7:0]    data_q;
    logic [9:0]    shift_q;
    logic [3:0]    bit_cnt;
    logic [IW-1:0] inh_cnt;
    logic [TW-1:0] to_cnt;
    logic          ack_ok;

    logic          accept;
    logic          timed_out;
    logic          retry_allowed;
    logic          enter_inhibit;
    logic          done_d;
    logic          ack_err_d;
    logic          timeout_err_d;

    ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_kclk_filter (
        .clk      (clk),
        .reset    (reset),
        .raw      (kclk_in),
        .filtered (kclk_filt),
        .fall     (kclk_fall)
    );

    ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_kdata_filter (
        .clk      (clk),
        .reset    (reset),
        .raw      (kdata_in),
        .filtered (kdata_filt),
        .fall     (kdata_fall_unused)
    );

    assign tx_ready      = (state == IDLE) && kclk_filt && !reset;
    assign accept        = tx_valid && tx_ready;
    assign busy          = (state != IDLE);
    // A device clock edge in the same cycle as expiry wins over the timeout.
    assign timed_out     = (to_cnt == TW'(TIMEOUT_CYCLES - 1)) && !kclk_fall;
    assign enter_inhibit = (state_d == INHIBIT) && (state != INHIBIT);

`ifdef PS2_TX_RETRY_EN
    localparam int RW = $clog2(MAX_RETRIES + 2);

    logic [RW-1:0] retry_cnt;

    assign retry_allowed = (retry_cnt < RW'(MAX_RETRIES));

    // Count resends of the current byte; a fresh byte starts from zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            retry_cnt <= '0;
        end else if (accept) begin
            retry_cnt <= '0;
        end else if (state == RELEASE && state_d == INHIBIT) begin
            retry_cnt <= retry_cnt + 1'b1;
        end
    end
`else
    // Never true: a NACK always ends the transfer in this build.
    assign retry_allowed = (MAX_RETRIES < 0);
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state, line drive and completion events.
    always_comb begin
        state_d       = state;
        kclk_oe       = 1'b0;
        kdata_oe      = 1'b0;
        done_d        = 1'b0;
        ack_err_d     = 1'b0;
        timeout_err_d = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_d = INHIBIT;
                end
            end
            INHIBIT: begin
                kclk_oe  = 1'b1;
                kdata_oe = (inh_cnt == '0);
                if (inh_cnt == '0) begin
                    state_d = START;
                end
            end
            START: begin
                kdata_oe = 1'b1;
                if (kclk_fall) begin
                    state_d = SEND;
                end else if (timed_out) begin
                    state_d       = IDLE;
                    timeout_err_d = 1'b1;
                end
            end
            SEND: begin
                kdata_oe = ~shift_q[0];
                if (kclk_fall) begin
                    if (bit_cnt == PS2_LAST_BIT) begin
                        state_d = ACK;
                    end
                end else if (timed_out) begin
                    state_d       = IDLE;
                    timeout_err_d = 1'b1;
                end
            end
            ACK: begin
                if (kclk_fall) begin
                    state_d = RELEASE;
                end else if (timed_out) begin
                    state_d       = IDLE;
                    timeout_err_d = 1'b1;
                end
            end
            RELEASE: begin
                if (kclk_filt && kdata_filt) begin
                    if (ack_ok) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else if (retry_allowed) begin
                        state_d = INHIBIT;
                    end else begin
                        state_d   = IDLE;
                        ack_err_d = 1'b1;
                    end
                end else if (timed_out) begin
                    state_d       = IDLE;
                    timeout_err_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Frame datapath: byte latch, shift frame, bit/inhibit/timeout counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            shift_q <= '0;
            bit_cnt <= '0;
            inh_cnt <= '0;
            to_cnt  <= '0;
            ack_ok  <= 1'b0;
        end else begin
            if (accept) begin
                data_q <= tx_data;
            end

            if (enter_inhibit) begin
                inh_cnt <= IW'(INHIBIT_CYCLES - 1);
                shift_q <= ps2_frame(accept ? tx_data : data_q);
            end else if (state == INHIBIT && inh_cnt != '0) begin
                inh_cnt <= inh_cnt - 1'b1;
            end

            if (state == START) begin
                bit_cnt <= '0;
            end else if (state == SEND && kclk_fall && bit_cnt != PS2_LAST_BIT) begin
                bit_cnt <= bit_cnt + 1'b1;
                shift_q <= {1'b1, shift_q[9:1]};
            end

            // Measures time since clock release or the latest device edge.
            if (state == IDLE || state == INHIBIT || kclk_fall) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end

            if (state == ACK && kclk_fall) begin
                ack_ok <= !kdata_filt;
            end
        end
    end

    // Registered completion pulses, aligned with the return to IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            done        <= 1'b0;
            ack_err     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            done        <= done_d;
            ack_err     <= ack_err_d;
            timeout_err <= timeout_err_d;
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a behavioural PS/2 device that
// clocks at a 40-cycle half period and can ACK or NACK the frame.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH = 100;
    localparam int TMO = 5000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       kclk_in;
    logic       kdata_in;
    logic       kclk_oe;
    logic       kdata_oe;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic       timeout_err;

    logic dev_clk_low = 1'b0;
    logic dev_data_low = 1'b0;

    assign kclk_in  = ~(kclk_oe | dev_clk_low);
    assign kdata_in = ~(kdata_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO),
        .FILTER_CYCLES  (3),
        .MAX_RETRIES    (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .kclk_in     (kclk_in),
        .kdata_in    (kdata_in),
        .kclk_oe     (kclk_oe),
        .kdata_oe    (kdata_oe),
        .busy        (busy),
        .done        (done),
        .ack_err     (ack_err),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Monitor state, sampled on the falling clock edge.
    int cyc = 0, n_frames = 0, inh_run = 0, kd_first = 0;
    int n_done = 0, n_done_bad = 0, n_ack_err = 0, n_to = 0, n_rdy_bad = 0;
    int start_cyc = 0, to_cyc = 0;
    logic [1:0] to_oe = 2'b00;
    logic prev_kclk_oe = 1'b0, prev_busy = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (kclk_oe) begin
            if (!prev_kclk_oe) begin
                n_frames++;
                inh_run  = 0;
                kd_first = 0;
            end
            inh_run++;
            if (kdata_oe && kd_first == 0) kd_first = inh_run;
        end
        if (prev_kclk_oe && !kclk_oe && kdata_oe) start_cyc = cyc;
        if (done) begin
            n_done++;
            if (busy || !prev_busy) n_done_bad++;
        end
        if (ack_err) n_ack_err++;
        if (timeout_err) begin
            n_to++;
            to_cyc = cyc;
            to_oe  = {kclk_oe, kdata_oe};
        end
        if (tx_ready && busy) n_rdy_bad++;
        prev_kclk_oe = kclk_oe;
        prev_busy    = busy;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d);
        int w = 0;
        while (!tx_ready && w < 500) begin
            tick();
            w++;
        end
        check("tx_ready_wait", 32'(w < 500), 32'd1);
        tx_data  = d;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
    endtask

    // Device side: wait for request-to-send, then clock n_clk pulses.
    // Host bits are read at the end of each low phase; clock 12 carries the ACK.
    task automatic dev_frame(input int n_clk, input logic ack_low,
                             output logic [9:0] bits, output logic ok);
        int w = 0;
        ok   = 1'b0;
        bits = '0;
        while (!(busy && !kclk_oe && kdata_oe) && w < 3000) begin
            tick();
            w++;
        end
        if (w >= 3000) return;
        ok = 1'b1;
        repeat (20) tick();
        for (int i = 1; i <= n_clk; i++) begin
            if (i == 12) begin
                dev_data_low = ack_low;
                repeat (10) tick();
            end
            dev_clk_low = 1'b1;
            repeat (40) tick();
            if (i <= 10) bits[i-1] = kdata_in;
            dev_clk_low = 1'b0;
            repeat (40) tick();
        end
        dev_data_low = 1'b0;
    endtask

    task automatic wait_idle();
        int w = 0;
        while (busy && w < 2000) begin
            tick();
            w++;
        end
        check("idle_wait", 32'(w < 2000), 32'd1);
        repeat (2) tick();
    endtask

    typedef struct {
        logic [7:0] data;
        logic [9:0] exp_bits;
    } vec_t;

    vec_t vecs[5];
    logic [9:0] bits, bits2;
    logic ok, ok2;
    int d0, e0, f0, b0;

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{PS2_CMD_SET_LEDS, 10'h3ED};
        vecs[1] = '{8'h00,            10'h300};
        vecs[2] = '{PS2_CMD_RESET,    10'h3FF};
        vecs[3] = '{8'h01,            10'h201};
        vecs[4] = '{PS2_CMD_ECHO,     10'h3EE};

        // Reset state
        repeat (3) tick();
        check("rst_kclk_oe", 32'(kclk_oe), 32'd0);
        check("rst_kdata_oe", 32'(kdata_oe), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pulses", {29'd0, done, ack_err, timeout_err}, 32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd0);
        reset = 1'b0;
        tick();
        check("post_rst_tx_ready", 32'(tx_ready), 32'd1);

        // Table of ACKed frames
        foreach (vecs[k]) begin
            d0 = n_done; e0 = n_ack_err; b0 = n_done_bad;
            fork
                send_byte(vecs[k].data);
                dev_frame(12, 1'b1, bits, ok);
            join
            wait_idle();
            check($sformatf("dev_start[%0d]", k), 32'(ok), 32'd1);
            check($sformatf("bits[%0d]", k), 32'(bits), 32'(vecs[k].exp_bits));
            check($sformatf("inhibit_len[%0d]", k), 32'(inh_run), 32'(INH));
            check($sformatf("kdata_rise[%0d]", k), 32'(kd_first), 32'(INH));
            check($sformatf("done_cnt[%0d]", k), 32'(n_done - d0), 32'd1);
            check($sformatf("ack_err_cnt[%0d]", k), 32'(n_ack_err - e0), 32'd0);
            check($sformatf("done_busy[%0d]", k), 32'(n_done_bad - b0), 32'd0);
        end

        // Device NACKs
        d0 = n_done; e0 = n_ack_err; f0 = n_frames;
`ifdef PS2_TX_RETRY_EN
        fork
            send_byte(8'h01);
            begin
                for (int r = 0; r < 3; r++) dev_frame(12, 1'b0, bits, ok);
            end
        join
        wait_idle();
        check("nack_frames", 32'(n_frames - f0), 32'd3);
        check("nack_ack_err", 32'(n_ack_err - e0), 32'd1);
        check("nack_done", 32'(n_done - d0), 32'd0);
        check("nack_last_bits", 32'(bits), 32'h201);

        d0 = n_done; e0 = n_ack_err; f0 = n_frames;
        fork
            send_byte(8'hED);
            begin
                dev_frame(12, 1'b0, bits, ok);
                dev_frame(12, 1'b1, bits2, ok2);
            end
        join
        wait_idle();
        check("retry_frames", 32'(n_frames - f0), 32'd2);
        check("retry_done", 32'(n_done - d0), 32'd1);
        check("retry_ack_err", 32'(n_ack_err - e0), 32'd0);
        check("retry_bits", 32'(bits2), 32'h3ED);
`else
        fork
            send_byte(8'h01);
            dev_frame(12, 1'b0, bits, ok);
        join
        wait_idle();
        check("nack_frames", 32'(n_frames - f0), 32'd1);
        check("nack_ack_err", 32'(n_ack_err - e0), 32'd1);
        check("nack_done", 32'(n_done - d0), 32'd0);
`endif

        // Device never clocks
        e0 = n_to;
        send_byte(PS2_CMD_ECHO);
        begin
            int w = 0;
            while (n_to == e0 && w < 7000) begin
                tick();
                w++;
            end
        end
        check("timeout_cnt", 32'(n_to - e0), 32'd1);
        check("timeout_latency", 32'(to_cyc - start_cyc), 32'(TMO));
        check("timeout_oe", 32'(to_oe), 32'd0);
        tick();
        check("timeout_busy", 32'(busy), 32'd0);

        // Reset in the middle of bit 4
        fork
            send_byte(PS2_CMD_SET_LEDS);
            dev_frame(5, 1'b1, bits, ok);
        join
        check("mid_busy", 32'(busy), 32'd1);
        check("mid_kdata_oe", 32'(kdata_oe), 32'd1);
        reset = 1'b1;
        tick();
        check("mid_rst_kclk_oe", 32'(kclk_oe), 32'd0);
        check("mid_rst_kdata_oe", 32'(kdata_oe), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_tx_ready", 32'(tx_ready), 32'd0);
        reset = 1'b0;
        tick();
        d0 = n_done;
        fork
            send_byte(PS2_CMD_RESET);
            dev_frame(12, 1'b1, bits, ok);
        join
        wait_idle();
        check("after_rst_bits", 32'(bits), 32'h3FF);
        check("after_rst_done", 32'(n_done - d0), 32'd1);

        // tx_valid held through a frame while the byte changes
        d0 = n_done; f0 = n_frames;
        tx_data  = PS2_CMD_ECHO;
        tx_valid = 1'b1;
        fork
            dev_frame(12, 1'b1, bits, ok);
            begin
                repeat (300) tick();
                tx_data = 8'h01;
            end
        join
        begin
            int w = 0;
            while (n_done == d0 && w < 500) begin
                tick();
                w++;
            end
        end
        check("hold_first_done", 32'(n_done - d0), 32'd1);
        check("hold_one_frame", 32'(n_frames - f0), 32'd1);
        check("hold_first_bits", 32'(bits), 32'h3EE);
        repeat (2) tick();
        tx_valid = 1'b0;
        check("hold_second_busy", 32'(busy), 32'd1);
        dev_frame(12, 1'b1, bits, ok);
        wait_idle();
        check("hold_second_bits", 32'(bits), 32'h201);
        check("hold_frames", 32'(n_frames - f0), 32'd2);
        check("hold_done", 32'(n_done - d0), 32'd2);
        check("ready_while_busy", 32'(n_rdy_bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter; sends one command byte to the keyboard, e.g. 0xED set-LEDs or 0xFF reset.
- Sits beside the existing PS/2 receiver on the same kclk/kdata pins.
- Drives the lines open-drain: an _oe output high pulls the pin low; the top level instantiates the tri-states.
- Checks the device ACK bit and reports done, NACK or timeout.

Parameters:
- INHIBIT_CYCLES, 12000, clk cycles the clock is held low before start (120 us at 100 MHz).
- TIMEOUT_CYCLES, 1500000, maximum clk cycles between consecutive kclk falling edges after clock release (15 ms).
- FILTER_CYCLES, 19, consecutive stable samples required before a filtered line changes.
- MAX_RETRIES, 2, retry count used only when PS2_TX_RETRY_EN is defined.

Ports:
- clk  in  1  system clock (100 MHz).
- reset  in  1  synchronous, active-high.
- tx_data  in  8  command byte.
- tx_valid  in  1  request; byte accepted when tx_valid && tx_ready.
- tx_ready  out  1  high in IDLE while filtered kclk is high.
- kclk_in  in  1  raw PS/2 clock pin.
- kdata_in  in  1  raw PS/2 data pin.
- kclk_oe  out  1  1 = pull kclk low.
- kdata_oe  out  1  1 = pull kdata low.
- busy  out  1  state != IDLE.
- done  out  1  1-cycle pulse: frame ACKed by device.
- ack_err  out  1  1-cycle pulse: device did not ACK.
- timeout_err  out  1  1-cycle pulse: device stopped clocking.

Behaviour:
- Reset (reset, synchronous, active-high; clock clk):
  - state=IDLE; kclk_oe=0, kdata_oe=0; done/ack_err/timeout_err=0; counters=0.
  - tx_ready is 0 during reset and may rise the cycle after, once filtered kclk=1.
  - Reset mid-frame releases both lines on the next edge. The device then times out on its own side.
- Inputs: 2-flop synchronizer, then glitch filter of FILTER_CYCLES. kclk_fall is a 1-cycle strobe on a filtered 1->0 transition.
- Accept:
  - Latch tx_data.
  - Compute parity = ~^tx_data (odd parity).
  - Load shift register {1'b1 stop, parity, tx_data}; LSB is sent first.
- IDLE -> INHIBIT on accept.
- INHIBIT:
  - kclk_oe=1 for exactly INHIBIT_CYCLES cycles.
  - kdata_oe rises in the last cycle.
  - Then -> START.
- START:
  - kclk_oe=0 (released), kdata_oe=1 (start bit 0).
  - bit_cnt=0; timeout counter cleared.
  - Wait for kclk_fall, then -> SEND.
- SEND:
  - On each kclk_fall, put the next shift bit on the line: kdata_oe = ~bit. bit_cnt increments 0..9.
  - Bits 0-7 are data, bit 8 is parity, bit 9 is stop (kdata_oe=0, released).
  - On the kclk_fall after bit_cnt=9 -> ACK.
- ACK:
  - Sample filtered kdata at the next kclk_fall: 0 = ACK, 1 = NACK.
  - Then -> RELEASE.
- RELEASE:
  - Wait until filtered kclk=1 and kdata=1.
  - Pulse done on ACK or ack_err on NACK; -> IDLE.
- Timeout:
  - In START/SEND/ACK/RELEASE, count cycles since clock release or the last kclk_fall.
  - At TIMEOUT_CYCLES: release both lines, pulse timeout_err, -> IDLE.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- Simultaneous events:
  - timeout_err and kclk_fall in the same cycle: the edge wins and the counter clears.
  - tx_valid while busy is ignored; no queuing.
- The receiver will see the transmitted frame and the 0xFA reply. Top level qualifies receiver output with busy.

Optional Feature:
- Macro: PS2_TX_RETRY_EN.
- Defined:
  - On NACK, return to INHIBIT with the same byte, up to MAX_RETRIES times.
  - ack_err pulses only after the final failure.
  - A retry counter (0..MAX_RETRIES) is cleared on accept.
  - Timeout is never retried.
- Undefined: ack_err pulses on the first NACK, with no retry logic.

Decomposition:
- Shared package ps2_pkg holds:
  - State typedef: IDLE, INHIBIT, START, SEND, ACK, RELEASE.
  - Constants PS2_CMD_SET_LEDS=8'hED, PS2_CMD_RESET=8'hFF, PS2_CMD_ECHO=8'hEE, PS2_RESP_ACK=8'hFA, PS2_RESP_RESEND=8'hFE.
- Sub-module ps2_line_filter (sync + FILTER_CYCLES filter + falling-edge strobe), instantiated twice. The receiver may later reuse it.

Test Plan:
- Bench parameters: INHIBIT_CYCLES=100, TIMEOUT_CYCLES=5000, FILTER_CYCLES=3. Device model clocks at 40-cycle half-period.
- Send 0xED with device ACK -> kclk_oe high exactly 100 cycles; data bits on line 1,0,1,1,0,1,1,1, parity 1, stop 1; done pulses once; busy falls the same cycle.
- Send 0x00 -> parity bit 1; 0xFF -> parity bit 1; 0x01 -> parity bit 0; all done.
- Device holds kdata high in ACK slot -> ack_err once.
  - With PS2_TX_RETRY_EN: 3 full frames observed, then ack_err.
  - With the frame ACKed on retry 1: done and no ack_err.
- Device never clocks after release -> timeout_err exactly 5000 cycles after START entry; both _oe = 0.
- Reset asserted at bit 4 -> next cycle kclk_oe=kdata_oe=0, busy=0; a new 0xFF then completes with done.
- tx_valid held through the frame with a second byte -> only one frame sent; second accepted only after tx_ready returns.
